// File: rtl/mfp_dot_accum.sv
// Streaming dot-product accumulator. Each beat of ArrL signed products is summed, the
// sums are accumulated over BeatN beats, and the total is rescaled, rounded and saturated.
module mfp_dot_accum #(
    parameter int ArrL     = 4,
    parameter int InW      = 7,
    parameter int BeatN    = 8,
    parameter int SumW     = InW + $clog2(ArrL),
    parameter int AccW     = SumW + $clog2(BeatN),
    parameter int OutW     = 8,
    parameter int OutShift = 2,
    parameter bit isFloor  = 1'b1,
    parameter bit Saturate = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [InW*ArrL-1:0]   in_arr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OutW-1:0]       out_data,
    output logic                  out_ovf
);

    localparam int CntW   = (BeatN > 1) ? $clog2(BeatN) : 1;
    // Rescale arithmetic is wide enough for both the accumulator and the clamp limits.
    localparam int RW     = (AccW + 1 > OutW + 1) ? AccW + 1 : OutW + 1;
    localparam int RndAdd = isFloor ? 0 : ((1 << OutShift) >> 1);
    localparam int MaxPos = (1 << (OutW - 1)) - 1;

    localparam logic signed [RW-1:0] SatHi = RW'(MaxPos);
    localparam logic signed [RW-1:0] SatLo = -SatHi;
    localparam logic [CntW-1:0]      LastCnt = CntW'(BeatN - 1);

    logic                   en;
    logic signed [SumW-1:0] beat_sum;
    logic signed [SumW-1:0] sum1;
    logic                   v1;
    logic [CntW-1:0]        cnt;
    logic signed [AccW-1:0] acc;
    logic signed [AccW-1:0] nxt;
    logic                   last_beat;
    logic signed [RW-1:0]   rx;
    logic signed [RW-1:0]   rt;
    logic [OutW-1:0]        res_data;
    logic                   res_ovf;

    // A result stuck at the output stalls the whole pipeline, including the input.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // NOTE: combinational accumulation uses blocking '=' so each loop pass sees the
    // previous partial sum; the variable is defaulted first so no latch is inferred.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < ArrL; i++) begin
            beat_sum = beat_sum + SumW'($signed(in_arr[i*InW +: InW]));
        end
    end

    // NOTE: every register holding state is updated with non-blocking '<=' so all
    // stages sample the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum1 <= '0;
            v1   <= 1'b0;
        end else if (en) begin
            sum1 <= beat_sum;
            v1   <= in_valid;
        end
    end

    assign last_beat = (cnt == LastCnt);
    assign nxt       = ((cnt == '0) ? '0 : acc) + AccW'(sum1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (en && v1) begin
            if (last_beat) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + CntW'(1);
                acc <= nxt;
            end
        end
    end

    always_comb begin
        rx       = RW'(nxt) + RW'(RndAdd);
        rt       = rx >>> OutShift;
        res_data = rt[OutW-1:0];
        res_ovf  = 1'b0;
        if (Saturate && (rt > SatHi)) begin
            res_data = OutW'(MaxPos);
            res_ovf  = 1'b1;
        end else if (Saturate && (rt < SatLo)) begin
            // Symmetric clamp: the most-negative code is never emitted.
            res_data = OutW'(-MaxPos);
            res_ovf  = 1'b1;
        end
    end

    // With en high any valid result is being consumed, so out_valid only survives when
    // a fresh result loads in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (en) begin
            if (v1 && last_beat) begin
                out_valid <= 1'b1;
                out_data  <= res_data;
                out_ovf   <= res_ovf;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mfp_dot_accum.sv
// Self-checking bench for mfp_dot_accum: directed test-plan cases plus randomized traffic
// scored against a beat-level arithmetic model; floor and round-half-up instances run in lockstep.
module tb_mfp_dot_accum;

    localparam int ArrL     = 4;
    localparam int InW      = 7;
    localparam int BeatN    = 8;
    localparam int OutW     = 8;
    localparam int OutShift = 2;
    localparam int SatMax   = (1 << (OutW - 1)) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_ready_r;
    logic [InW*ArrL-1:0]  in_arr;
    logic                 out_ready;
    logic                 out_valid;
    logic                 out_valid_r;
    logic [OutW-1:0]      out_data;
    logic [OutW-1:0]      out_data_r;
    logic                 out_ovf;
    logic                 out_ovf_r;

    always #5 clk = ~clk;

    mfp_dot_accum #(.isFloor(1'b1)) u_dut_floor (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_arr(in_arr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    mfp_dot_accum #(.isFloor(1'b0)) u_dut_round (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .in_arr(in_arr),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r), .out_ovf(out_ovf_r)
    );

    typedef struct {
        int df;
        int of;
        int dr;
        int orr;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   acc_m     = 0;
    int   cnt_m     = 0;
    int   beats_m   = 0;
    int   results_m = 0;
    int   valid_cycles = 0;
    int   last_df, last_of, last_dr, last_or;
    int   prev_data, prev_ovf;
    bit   hold_prev = 1'b0;
    bit   chk_lat   = 1'b0;
    bit   saw_stall = 1'b0;
    logic last_in_ready;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int floor_div(input int x);
        int d;
        d = 1 << OutShift;
        return (x >= 0) ? x / d : -((-x + d - 1) / d);
    endfunction

    function automatic int clamp(input int t);
        if (t > SatMax) return SatMax;
        if (t < -SatMax) return -SatMax;
        return t;
    endfunction

    function automatic logic [InW*ArrL-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [InW-1:0] e0, e1, e2, e3;
        e0 = InW'(a);
        e1 = InW'(b);
        e2 = InW'(c);
        e3 = InW'(d);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic [InW*ArrL-1:0] pack_all(input int v);
        return pack4(v, v, v, v);
    endfunction

    function automatic int beat_total(input logic [InW*ArrL-1:0] arr);
        logic signed [InW-1:0] e;
        int s;
        s = 0;
        for (int i = 0; i < ArrL; i++) begin
            e = arr[i*InW +: InW];
            s += int'(e);
        end
        return s;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        acc_m     = 0;
        cnt_m     = 0;
        hold_prev = 1'b0;
    endtask

    // One clock cycle: drive, sample at the falling edge, score, then advance past the rising edge.
    task automatic step(input logic v, input logic [InW*ArrL-1:0] arr, input logic rdy);
        exp_t e;
        int   tf, tr;
        in_valid  = v;
        in_arr    = arr;
        out_ready = rdy;
        @(negedge clk);
        last_in_ready = in_ready;
        check("in_ready_rule", in_ready, !(out_valid && !out_ready));
        if (!in_ready) saw_stall = 1'b1;
        if (out_valid) valid_cycles++;
        if (hold_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", int'($signed(out_data)), prev_data);
            check("hold_ovf", out_ovf, prev_ovf);
        end
        if (out_valid && out_ready) begin
            check("result_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("data_floor", int'($signed(out_data)), e.df);
                check("ovf_floor", out_ovf, e.of);
                check("valid_round", out_valid_r, 1);
                check("data_round", int'($signed(out_data_r)), e.dr);
                check("ovf_round", out_ovf_r, e.orr);
                if (chk_lat) check("latency", cyc, e.due);
                last_df = int'($signed(out_data));
                last_of = out_ovf;
                last_dr = int'($signed(out_data_r));
                last_or = out_ovf_r;
                results_m++;
            end
        end
        if (in_valid && in_ready) begin
            acc_m += beat_total(in_arr);
            beats_m++;
            cnt_m++;
            if (cnt_m == BeatN) begin
                tf    = floor_div(acc_m);
                tr    = floor_div(acc_m + ((1 << OutShift) >> 1));
                e.df  = clamp(tf);
                e.of  = (e.df != tf);
                e.dr  = clamp(tr);
                e.orr = (e.dr != tr);
                e.due = cyc + 2;
                exp_q.push_back(e);
                acc_m = 0;
                cnt_m = 0;
            end
        end
        hold_prev = out_valid && !out_ready;
        prev_data = int'($signed(out_data));
        prev_ovf  = out_ovf;
        @(posedge clk);
        #1;
    endtask

    task automatic run_dot(input logic [InW*ArrL-1:0] first, input logic [InW*ArrL-1:0] rest);
        step(1'b1, first, 1'b1);
        for (int i = 1; i < BeatN; i++) step(1'b1, rest, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    endtask

    // Reset is asserted and released between clock edges.
    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_out_valid_round", out_valid_r, 0);
        #2;
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, r0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_arr    = '0;
        out_ready = 1'b1;
        #12;
        check("init_out_valid", out_valid, 0);
        check("init_out_data", int'(out_data), 0);
        check("init_out_ovf", out_ovf, 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("init_in_ready", in_ready, 1);

        // All ones: acc 32 -> 8, latency two cycles, valid for a single cycle.
        chk_lat      = 1'b1;
        valid_cycles = 0;
        run_dot(pack_all(1), pack_all(1));
        check("ones_valid_cycles", valid_cycles, 1);
        check("ones_data", last_df, 8);
        check("ones_ovf", last_of, 0);
        check("ones_data_round", last_dr, 8);

        run_dot(pack_all(63), pack_all(63));
        check("max_data", last_df, 127);
        check("max_ovf", last_of, 1);
        run_dot(pack_all(-64), pack_all(-64));
        check("min_data", last_df, -127);
        check("min_ovf", last_of, 1);
        check("min_data_round", last_dr, -127);

        run_dot(pack4(3, 3, 0, 0), pack_all(0));
        check("pos6_floor", last_df, 1);
        check("pos6_round", last_dr, 2);
        run_dot(pack4(-3, -3, 0, 0), pack_all(0));
        check("neg6_floor", last_df, -2);
        check("neg6_round", last_dr, -1);
        chk_lat = 1'b0;

        // Backpressure: no consumer for the first 30 cycles, continuous distinct beats.
        b0        = beats_m;
        r0        = results_m;
        saw_stall = 1'b0;
        for (int c = 0; c < 80; c++) begin
            int j;
            j = beats_m - b0;
            step(j < 16, pack4(j - 8, j, 2 * j - 5, 3), c >= 30);
        end
        check("bp_beats", beats_m - b0, 16);
        check("bp_results", results_m - r0, 2);
        check("bp_stalled", saw_stall, 1);

        // Reset mid dot product, then a clean one.
        for (int i = 0; i < 3; i++) step(1'b1, pack_all(1), 1'b1);
        do_reset();
        run_dot(pack_all(2), pack_all(2));
        check("post_rst_data", last_df, 16);

        // Reset while a result is held under backpressure.
        for (int i = 0; i < BeatN; i++) step(1'b1, pack_all(1), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
        check("held_before_rst", out_valid, 1);
        do_reset();

        // Streaming: four back-to-back dot products with no bubbles.
        chk_lat = 1'b1;
        r0      = results_m;
        for (int i = 0; i < 4 * BeatN; i++) begin
            step(1'b1, pack_all(i / BeatN + 1), 1'b1);
            check("stream_in_ready", last_in_ready, 1);
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        check("stream_results", results_m - r0, 4);
        check("stream_last", last_df, 32);
        chk_lat = 1'b0;

        // Randomized traffic and backpressure.
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 9) < 7, (InW*ArrL)'($urandom()), $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
        check("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mfp_dot_accum.md
Name: mfp_dot_accum

Overview:
- Streaming dot-product accumulator directly downstream of the fixed-point multiplier array stage.
- Each beat takes ArrL signed products, sums them, and accumulates over BeatN beats.
- Each finished dot product is rescaled, rounded and saturated to OutW bits.
- Used in the SIFT descriptor/convolution datapath; valid/ready handshake on both sides.

Parameters:
- ArrL, 4: products per input beat.
- InW, 7: signed width of each product (matches multiplier output In1W+In2W-1 for 4x4).
- BeatN, 8: beats per dot product; must be ≥1.
- SumW, InW+$clog2(ArrL): per-beat sum width; derived, do not override.
- AccW, SumW+$clog2(BeatN): accumulator width; overflow-free by construction.
- OutW, 8: signed output width.
- OutShift, 2: LSBs dropped from accumulator before output (arithmetic right shift); 0 = none.
- isFloor, 1: 1 = truncate toward -inf; 0 = round half up (add 2^(OutShift-1) before shift).
- Saturate, 1: 1 = clamp to ±(2^(OutW-1)-1); 0 = keep low OutW bits (wrap).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_arr  in  InW*ArrL  packed signed products; element i at [i*InW +: InW].
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  OutW  signed dot-product result.
- out_ovf  out  1  saturation occurred on this result; qualified by out_valid.

Behaviour:
- Reset (async, any time): out_valid=0, out_data=0, out_ovf=0, beat counter=0, accumulator=0, stage-1 valid=0. Any partial dot product is discarded. in_ready=1 after rst deasserts.
- Global enable: en = !(out_valid && !out_ready); in_ready = en. When en=0 all pipeline registers hold.
- Stage 1 (en=1):
  - sum1 <= sign-extended sum of the ArrL elements (SumW bits).
  - v1 <= in_valid.
- Stage 2 (en=1 and v1=1):
  - nxt = (cnt==0 ? 0 : acc) + sext(sum1) at AccW.
  - If cnt < BeatN-1: acc <= nxt, cnt <= cnt+1.
  - If cnt == BeatN-1: cnt <= 0, acc <= 0, out_data <= R(nxt), out_ovf <= sat flag, out_valid <= 1.
- Output:
  - out_valid clears on handshake unless a new result loads in the same cycle; if it does, out_valid stays 1 with the new data.
  - out_data and out_ovf stay stable while out_valid && !out_ready.
- R(x):
  - t = isFloor ? x>>>OutShift : (x + 2^(OutShift-1))>>>OutShift, computed at AccW+1 bits (no intermediate overflow).
  - If Saturate and t > 2^(OutW-1)-1: output +max, ovf=1.
  - If Saturate and t < -(2^(OutW-1)-1): output -(2^(OutW-1)-1), ovf=1. The most-negative code is never produced.
  - Otherwise output t[OutW-1:0], ovf=0.
- Latency: last beat accepted at cycle T → out_valid high from cycle T+2.
- Throughput: one beat per cycle. With out_ready held 1, one result every BeatN cycles with no bubbles.
- BeatN=1: every beat produces a result.
- Beat count is positional only. There is no framing input; the upstream stage guarantees alignment.

Test Plan:
- Defaults; 8 beats, all elements = 1; out_ready=1 → out_data=8 (acc 32 >>2), out_ovf=0, out_valid exactly 2 cycles after 8th beat handshake, high for 1 cycle.
- 8 beats all elements = 63 → acc 2016 → out_data=127, out_ovf=1. 8 beats all elements = -64 → out_data=-127 (0x81), out_ovf=1.
- Beat0 = {3,3,0,0}, beats 1-7 = 0:
  - isFloor=1 → out_data=1.
  - isFloor=0 → out_data=2.
  - Same with {-3,-3,0,0}: isFloor=1 → -2; isFloor=0 → -1.
- Backpressure: out_ready=0 after first result, continuous in_valid → in_ready drops while out_valid && !out_ready, first out_data held stable. Raise out_ready → second result arrives with correct value; total beats consumed = 16, none lost or duplicated.
- Reset mid-operation: 3 beats of 1s, pulse rst asynchronously (between edges) → out_valid=0 immediately. Then 8 beats of 2s → out_data=16, no contribution from the pre-reset beats.
- Streaming: 32 consecutive beats with value k on beat group k (k=1..4), out_ready=1 → results 8, 16, 24, 32 at 8-cycle spacing, in_ready constantly 1.
